// File: rtl/pio_bank_pkg.sv
// Shared encodings for the PIO bank: register select codes, edge modes
// and a constant-evaluable ceiling log2.
package pio_bank_pkg;

   typedef enum logic [1:0] {
      SEL_OUT  = 2'd0,
      SEL_IN   = 2'd1,
      SEL_EDGE = 2'd2,
      SEL_MASK = 2'd3
   } sel_e;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/pio_bank_debounce.sv
// One input channel: two-flop synchroniser, whole-word debounce and
// edge detection on the debounced value.
module pio_debounce
   import pio_bank_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                DEB_CYC   = 50000,
   parameter int                EDGE_MODE = EDGE_RISE,
   parameter logic [DATA_W-1:0] IN_RST    = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] pin,
   output logic [DATA_W-1:0] stable,
   output logic [DATA_W-1:0] edge_det
);

   localparam int CNT_W = (clog2(DEB_CYC + 1) < 1) ? 1 : clog2(DEB_CYC + 1);

   logic [DATA_W-1:0] sync_meta;
   logic [DATA_W-1:0] sync_out;
   logic [DATA_W-1:0] stable_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta   <= IN_RST;
         sync_out    <= IN_RST;
         stable_prev <= IN_RST;
      end else begin
         sync_meta   <= pin;
         sync_out    <= sync_meta;
         stable_prev <= stable;
      end
   end

   generate
      if (DEB_CYC == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) stable <= IN_RST;
            else          stable <= sync_out;
         end
      end else begin : g_count
         logic [CNT_W-1:0]  cnt;
         logic [CNT_W-1:0]  cnt_eff;
         logic [DATA_W-1:0] sync_prev;

         // A new differing value restarts the stability count from zero
         always_comb cnt_eff = (sync_out != sync_prev) ? '0 : cnt;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt       <= '0;
               stable    <= IN_RST;
               sync_prev <= IN_RST;
            end else begin
               sync_prev <= sync_out;
               if (sync_out == stable) begin
                  cnt <= '0;
               end else if (cnt_eff == CNT_W'(DEB_CYC - 1)) begin
                  stable <= sync_out;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt_eff + CNT_W'(1);
               end
            end
         end
      end
   endgenerate

   always_comb begin
      edge_det = '0;
      case (EDGE_MODE)
         EDGE_RISE: edge_det = stable & ~stable_prev;
         EDGE_FALL: edge_det = ~stable & stable_prev;
         default:   edge_det = stable ^ stable_prev;
      endcase
   end

endmodule

// File: rtl/pio_bank_avmm.sv
// Avalon-MM PIO bank: output words, debounced input words with edge
// capture, per-channel interrupt mask and a registered level IRQ.
module pio_bank_avmm
   import pio_bank_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                N_OUT     = 4,
   parameter int                N_IN      = 2,
   parameter int                DEB_CYC   = 50000,
   parameter int                EDGE_MODE = EDGE_RISE,
   parameter logic [DATA_W-1:0] OUT_RST   = '0,
   parameter logic [DATA_W-1:0] IN_RST    = '0,
   localparam int MAX_CH = (N_OUT > N_IN) ? N_OUT : N_IN,
   localparam int IDX_W  = (clog2(MAX_CH) < 1) ? 1 : clog2(MAX_CH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [IDX_W+1:0]         avs_address,
   input  logic                     avs_read,
   input  logic                     avs_write,
   input  logic [31:0]              avs_writedata,
   input  logic [3:0]               avs_byteenable,
   output logic [31:0]              avs_readdata,
   output logic                     irq,
   output logic [N_OUT*DATA_W-1:0]  out_export,
   input  logic [N_IN*DATA_W-1:0]   in_export
);

   sel_e              sel;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       be_mask;
   logic [DATA_W-1:0] wmask;
   logic [DATA_W-1:0] wdata;
   logic [31:0]       rd_mux;
   logic              irq_next;

   logic [DATA_W-1:0] out_reg  [N_OUT];
   logic [DATA_W-1:0] stable   [N_IN];
   logic [DATA_W-1:0] edge_det [N_IN];
   logic [DATA_W-1:0] edge_reg [N_IN];
   logic [DATA_W-1:0] edge_clr [N_IN];
   logic [DATA_W-1:0] mask_reg [N_IN];
   logic              mask_wr  [N_IN];

   assign sel     = sel_e'(avs_address[IDX_W+1:IDX_W]);
   assign idx     = avs_address[IDX_W-1:0];
   assign be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                     {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
   assign wmask   = be_mask[DATA_W-1:0];
   assign wdata   = avs_writedata[DATA_W-1:0];

   generate
      for (genvar g = 0; g < N_OUT; g++) begin : g_out
         assign out_export[g*DATA_W +: DATA_W] = out_reg[g];
      end
      for (genvar g = 0; g < N_IN; g++) begin : g_in
         pio_debounce #(
            .DATA_W    (DATA_W),
            .DEB_CYC   (DEB_CYC),
            .EDGE_MODE (EDGE_MODE),
            .IN_RST    (IN_RST)
         ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin      (in_export[g*DATA_W +: DATA_W]),
            .stable   (stable[g]),
            .edge_det (edge_det[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N_OUT; k++) out_reg[k] <= OUT_RST;
      end else if (avs_write && sel == SEL_OUT) begin
         for (int k = 0; k < N_OUT; k++)
            if (idx == IDX_W'(k)) out_reg[k] <= (out_reg[k] & ~wmask) | (wdata & wmask);
      end
   end

   always_comb begin
      for (int k = 0; k < N_IN; k++) begin
         edge_clr[k] = '0;
         mask_wr[k]  = 1'b0;
         if (avs_write && idx == IDX_W'(k)) begin
            if (sel == SEL_EDGE) edge_clr[k] = wdata & wmask;
            if (sel == SEL_MASK) mask_wr[k]  = 1'b1;
         end
      end
   end

   // Newly detected edges are OR-ed in after the clear so a set wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N_IN; k++) begin
            edge_reg[k] <= '0;
            mask_reg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            edge_reg[k] <= (edge_reg[k] & ~edge_clr[k]) | edge_det[k];
            if (mask_wr[k]) mask_reg[k] <= (mask_reg[k] & ~wmask) | (wdata & wmask);
         end
      end
   end

   always_comb begin
      irq_next = 1'b0;
      for (int k = 0; k < N_IN; k++) irq_next = irq_next | (|(edge_reg[k] & mask_reg[k]));
   end

   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < N_OUT; k++)
         if (sel == SEL_OUT && idx == IDX_W'(k)) rd_mux[DATA_W-1:0] = out_reg[k];
      for (int k = 0; k < N_IN; k++) begin
         if (idx == IDX_W'(k)) begin
            case (sel)
               SEL_IN:   rd_mux[DATA_W-1:0] = stable[k];
               SEL_EDGE: rd_mux[DATA_W-1:0] = edge_reg[k];
               SEL_MASK: rd_mux[DATA_W-1:0] = mask_reg[k];
               default:  ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avs_readdata <= '0;
         irq          <= 1'b0;
      end else begin
         if (avs_read) avs_readdata <= rd_mux;
         irq <= irq_next;
      end
   end

endmodule

// File: tb/tb_pio_bank_avmm.sv
// Scoreboard bench for pio_bank_avmm: reads push expected data, a monitor
// compares readdata the cycle after each read; level outputs checked directly.
module tb_pio_bank_avmm;

   localparam int DATA_W  = 32;
   localparam int N_OUT   = 4;
   localparam int N_IN    = 2;
   localparam int DEB_CYC = 4;
   localparam int IDX_W   = 2;

   logic                    clk;
   logic                    reset_n;
   logic [IDX_W+1:0]        avs_address;
   logic                    avs_read;
   logic                    avs_write;
   logic [31:0]             avs_writedata;
   logic [3:0]              avs_byteenable;
   logic [31:0]             avs_readdata;
   logic                    irq;
   logic [N_OUT*DATA_W-1:0] out_export;
   logic [N_IN*DATA_W-1:0]  in_export;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   logic        rd_pend;

   pio_bank_avmm #(
      .DATA_W    (DATA_W),
      .N_OUT     (N_OUT),
      .N_IN      (N_IN),
      .DEB_CYC   (DEB_CYC),
      .EDGE_MODE (0),
      .OUT_RST   (32'h0000_00FF),
      .IN_RST    (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .avs_address    (avs_address),
      .avs_read       (avs_read),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .avs_byteenable (avs_byteenable),
      .avs_readdata   (avs_readdata),
      .irq            (irq),
      .out_export     (out_export),
      .in_export      (in_export)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_pend <= 1'b0;
      else          rd_pend <= avs_read;
   end

   // Monitor: readdata is valid the cycle after each accepted read
   always @(negedge clk) begin
      if (rd_pend) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL read_unexpected: readdata=%h, required no response", avs_readdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if (avs_readdata !== mon_exp) begin
               errors++;
               $display("[TB] FAIL readdata: got %h, expected %h at %0t", avs_readdata, mon_exp, $time);
            end
         end
      end
   end

   task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] sel,
                                input logic [IDX_W-1:0] idx, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] exp_rd);
      avs_read       = rd;
      avs_write      = wr;
      avs_address    = {sel, idx};
      avs_writedata  = wdata;
      avs_byteenable = be;
      if (rd) exp_q.push_back(exp_rd);
      @(negedge clk);
      avs_read  = 1'b0;
      avs_write = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic doWrite(input logic [1:0] sel, input logic [IDX_W-1:0] idx,
                          input logic [31:0] wdata, input logic [3:0] be);
      applyStimulus(1'b0, 1'b1, sel, idx, wdata, be, 32'h0);
   endtask

   task automatic doRead(input logic [1:0] sel, input logic [IDX_W-1:0] idx, input logic [31:0] exp);
      applyStimulus(1'b1, 1'b0, sel, idx, 32'h0, 4'h0, exp);
   endtask

   task automatic doIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, '0, 32'h0, 4'h0, 32'h0);
   endtask

   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset_n        = 1'b0;
      avs_address    = '0;
      avs_read       = 1'b0;
      avs_write      = 1'b0;
      avs_writedata  = '0;
      avs_byteenable = '0;
      in_export      = '0;

      // Reset values
      #12;
      for (int k = 0; k < N_OUT; k++) checkOutput($sformatf("reset_out_ch%0d", k), out_export[k*32 +: 32], 32'h0000_00FF);
      checkOutput("reset_readdata", avs_readdata, 32'h0);
      checkOutput("reset_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Output registers with byte enables and read-during-write
      doWrite(2'd0, 2'd1, 32'hA5A5_1234, 4'b0011);
      checkOutput("out_ch1_be", out_export[32 +: 32], 32'h0000_1234);
      checkOutput("out_ch0_kept", out_export[0 +: 32], 32'h0000_00FF);
      doRead(2'd0, 2'd1, 32'h0000_1234);
      doWrite(2'd0, 2'd2, 32'hDEAD_BEEF, 4'b1010);
      applyStimulus(1'b1, 1'b1, 2'd0, 2'd2, 32'h1111_1111, 4'hF, 32'hDE00_BEFF);
      doRead(2'd0, 2'd2, 32'h1111_1111);
      checkOutput("out_ch2", out_export[64 +: 32], 32'h1111_1111);
      doRead(2'd0, 2'd3, 32'h0000_00FF);

      // Debounce latency: stable changes on the 6th edge after the pin
      in_export[31:0] = 32'h1;
      doIdle(5);
      doRead(2'd1, 2'd0, 32'h0);
      doRead(2'd1, 2'd0, 32'h1);
      doRead(2'd2, 2'd0, 32'h1);

      // Three-cycle glitch must not reach stable
      in_export[31:0] = 32'h3;
      doIdle(3);
      in_export[31:0] = 32'h1;
      doIdle(10);
      doRead(2'd1, 2'd0, 32'h1);
      doRead(2'd2, 2'd0, 32'h1);
      checkOutput("irq_unmasked", {31'h0, irq}, 32'h0);

      // Mask and irq timing
      doWrite(2'd2, 2'd0, 32'hFFFF_FFFF, 4'hF);
      doWrite(2'd3, 2'd0, 32'h1, 4'hF);
      doRead(2'd3, 2'd0, 32'h1);
      doIdle(1);
      checkOutput("irq_no_edge", {31'h0, irq}, 32'h0);
      in_export[31:0] = 32'h0;
      doIdle(10);
      doRead(2'd2, 2'd0, 32'h0);
      in_export[31:0] = 32'h1;
      doIdle(7);
      checkOutput("irq_before", {31'h0, irq}, 32'h0);
      doIdle(1);
      checkOutput("irq_rise", {31'h0, irq}, 32'h1);

      // Clear in the same cycle as a new rise: set wins
      in_export[31:0] = 32'h0;
      doIdle(10);
      in_export[31:0] = 32'h1;
      doIdle(6);
      doWrite(2'd2, 2'd0, 32'h1, 4'hF);
      checkOutput("irq_set_wins_a", {31'h0, irq}, 32'h1);
      doIdle(1);
      checkOutput("irq_set_wins_b", {31'h0, irq}, 32'h1);
      doRead(2'd2, 2'd0, 32'h1);
      doWrite(2'd2, 2'd0, 32'hFFFF_FFFF, 4'b1110);
      doIdle(1);
      checkOutput("irq_be_gated_clear", {31'h0, irq}, 32'h1);
      doWrite(2'd2, 2'd0, 32'h1, 4'hF);
      checkOutput("irq_clear_lag", {31'h0, irq}, 32'h1);
      doIdle(1);
      checkOutput("irq_cleared", {31'h0, irq}, 32'h0);
      doRead(2'd2, 2'd0, 32'h0);

      // Out-of-range indices and read-only inputs
      doRead(2'd1, 2'd3, 32'h0);
      doRead(2'd2, 2'd3, 32'h0);
      doRead(2'd3, 2'd2, 32'h0);
      doWrite(2'd1, 2'd0, 32'h0, 4'hF);
      doRead(2'd1, 2'd0, 32'h1);

      // Asynchronous reset in the middle of a debounce count
      in_export[31:0] = 32'h0;
      doIdle(10);
      in_export[31:0] = 32'h1;
      doIdle(8);
      checkOutput("irq_pre_reset", {31'h0, irq}, 32'h1);
      in_export[63:32] = 32'h5;
      doRead(2'd0, 2'd1, 32'h0000_1234);
      doIdle(2);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_irq", {31'h0, irq}, 32'h0);
      checkOutput("async_readdata", avs_readdata, 32'h0);
      checkOutput("async_out_ch1", out_export[32 +: 32], 32'h0000_00FF);
      @(negedge clk);
      reset_n = 1'b1;
      doRead(2'd1, 2'd1, 32'h0);
      doRead(2'd2, 2'd0, 32'h0);
      doIdle(3);
      doRead(2'd1, 2'd1, 32'h0);
      doRead(2'd1, 2'd1, 32'h5);
      doRead(2'd3, 2'd0, 32'h0);
      doIdle(4);
      checkOutput("irq_mask_reset", {31'h0, irq}, 32'h0);

      doIdle(2);
      checkOutput("scoreboard_drained", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
